bus_mux_pipe: RTL and testbench
===============================

Name: bus_mux_pipe

Overview:
- Parametrised, registered N-to-1 datapath bus multiplexer with a valid/ready handshake and a two-entry skid buffer.
- Sustains one transfer per cycle under back-pressure.
- Out-of-range selects are dropped cleanly instead of holding a stale value, and are reported through a sticky error flag and a drop counter.
- Sits between register-file/ALU result sources and the shared datapath bus; it is the pipelined successor to the existing fixed 3-input bus mux.

Parameters:
- WIDTH, 32, bit width of each data input and of the output.
- NUM_IN, 3, number of data inputs; legal range 2..16.
- SEL_W, 2, select width; must satisfy 2**SEL_W >= NUM_IN.

Ports:
- clk  in  1  rising-edge clock.
- clr  in  1  synchronous active-high reset.
- in_data  in  NUM_IN*WIDTH  flattened inputs; input i occupies bits [i*WIDTH +: WIDTH].
- in_sel  in  SEL_W  binary select for the current request.
- in_valid  in  1  request present.
- in_ready  out  1  block can accept a request this cycle.
- out_data  out  WIDTH  selected data.
- out_sel  out  SEL_W  select value that produced out_data.
- out_valid  out  1  out_data/out_sel valid.
- out_ready  in  1  consumer accepts the output this cycle.
- err_sel  out  1  sticky flag: at least one out-of-range select has been accepted.
- err_clr  in  1  clears err_sel and drop_count.
- drop_count  out  8  saturating count of dropped requests.

Behaviour:
- Clock and reset: single clock domain. clr is synchronous active-high and sampled only on the rising edge of clk.

Reset (clr=1 at an edge):
- in_ready=1 after the edge.
- out_valid=0, out_data=0, out_sel=0.
- err_sel=0, drop_count=0.
- Skid register emptied.
- clr overrides every other input in that cycle, including an in-flight handshake: a request or output transfer coinciding with clr is lost.

Handshake rules:
- Accept: in_valid && in_ready at an edge.
- Output transfer: out_valid && out_ready at an edge.
- Once out_valid=1, out_data and out_sel are held stable until the transfer completes.

Storage and state:
- Two registers: main (drives the outputs) and skid.
- States: EMPTY (main invalid), ONE (main valid, skid empty), FULL (both valid).
- in_ready = !skid_valid. It is registered, not a combinational function of out_ready.

Transitions on an in-range accept:
- EMPTY + accept: request loads main; goes to ONE.
- ONE + accept + output transfer: request loads main; stays ONE.
- ONE + accept, no transfer: request loads skid; goes to FULL.
- ONE + transfer, no accept: goes to EMPTY.
- FULL + transfer: skid moves to main; goes to ONE. No accept is possible in FULL.
- FULL, no transfer: all registers hold.

Latency and throughput:
- Latency from accept edge to out_valid is 1 cycle; data is visible in the cycle after the accept edge.
- Throughput is 1 transfer/cycle when out_ready is held high.
- Ordering is strict FIFO: skid data always leaves before any newer request.

Select rules:
- Data captured is in_data[in_sel*WIDTH +: WIDTH], sampled at the accept edge.
- Out-of-range select (in_sel >= NUM_IN) is still accepted (in_ready is unaffected) but not stored, and the state is unchanged by it.
- Such a select sets err_sel=1 and increments drop_count, which saturates at 255.
- err_clr at an edge zeroes err_sel and drop_count. If an out-of-range accept occurs in the same cycle, the result is err_sel=1 and drop_count=1 (set wins over clear).

Other rules:
- No latches: every output is driven from registers under all select values.

Test Plan:
1. Reset, then steady stream: clr for 2 cycles, NUM_IN=3, WIDTH=32, inputs 0xAAAA0000/0xBBBB1111/0xCCCC2222, out_ready=1, selects 0,1,2 on consecutive cycles -> out_data equals those three values on the three cycles following each accept; out_sel=0,1,2; in_ready stays 1.
2. Back-pressure: out_ready=0, then send sel=1 and sel=2 -> after the second accept in_ready=0 and out_data=0xBBBB1111 is held. Raise out_ready -> 0xBBBB1111 then 0xCCCC2222 in order; in_ready returns to 1 one cycle after the first transfer.
3. Out-of-range select: send sel=3 between sel=0 and sel=1 -> output shows only 0xAAAA0000, then 0xBBBB1111; err_sel=1, drop_count=1.
4. Saturation and clear: send 300 requests with sel=3 -> drop_count=255, err_sel=1. Pulse err_clr alone -> both read 0. Pulse err_clr together with a sel=3 accept -> err_sel=1, drop_count=1.
5. Reset mid-operation: reach FULL with out_ready=0, then assert clr for 1 cycle -> next cycle out_valid=0, in_ready=1, out_data=0, and no stale data appears after reset.

Source files
------------

// File: rtl/bus_mux_pipe.sv
// bus_mux_pipe: registered N-to-1 bus multiplexer with a valid/ready handshake and a two-entry
// skid buffer (main + skid). Sustains one transfer per cycle under back-pressure.
//
// Ports:
//   clk         rising-edge clock
//   clr         synchronous active-high reset
//   in_data     NUM_IN flattened inputs, input i at [i*WIDTH +: WIDTH]
//   in_sel      binary select of the current request
//   in_valid    request present
//   in_ready    block can accept a request (registered: low only while skid is occupied)
//   out_data    selected data
//   out_sel     select value that produced out_data
//   out_valid   out_data/out_sel valid
//   out_ready   consumer accepts the output
//   err_sel     sticky: an out-of-range select has been accepted
//   err_clr     clears err_sel and drop_count
//   drop_count  saturating count of dropped (out-of-range) requests
module bus_mux_pipe #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned NUM_IN = 3,
   parameter int unsigned SEL_W  = 2
) (
   input  logic                    clk,
   input  logic                    clr,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic [SEL_W-1:0]        in_sel,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic [SEL_W-1:0]        out_sel,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    err_sel,
   input  logic                    err_clr,
   output logic [7:0]              drop_count
);

   typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

   state_e              state_q, state_d;
   logic [WIDTH-1:0]    main_data_q, main_data_d;
   logic [SEL_W-1:0]    main_sel_q, main_sel_d;
   logic [WIDTH-1:0]    skid_data_q, skid_data_d;
   logic [SEL_W-1:0]    skid_sel_q, skid_sel_d;
   logic                err_q, err_d;
   logic [7:0]          drop_q, drop_d;

   logic [WIDTH-1:0]    req_data;
   logic                in_range;
   logic                accept;
   logic                xfer;
   logic                push;
   logic                drop;

   // Explicit compare-per-input mux so out-of-range selects never index past in_data.
   always_comb begin
      req_data = '0;
      for (int unsigned i = 0; i < NUM_IN; i++) begin
         if (in_sel == SEL_W'(i)) req_data = in_data[i*WIDTH +: WIDTH];
      end
   end

   assign in_range = 32'(in_sel) < NUM_IN;
   assign accept   = in_valid && in_ready;
   assign xfer     = out_valid && out_ready;
   assign push     = accept && in_range;
   assign drop     = accept && !in_range;

   always_comb begin
      state_d     = state_q;
      main_data_d = main_data_q;
      main_sel_d  = main_sel_q;
      skid_data_d = skid_data_q;
      skid_sel_d  = skid_sel_q;
      unique case (state_q)
         StEmpty: begin
            if (push) begin
               main_data_d = req_data;
               main_sel_d  = in_sel;
               state_d     = StOne;
            end
         end
         StOne: begin
            if (push && xfer) begin
               main_data_d = req_data;
               main_sel_d  = in_sel;
            end else if (push) begin
               skid_data_d = req_data;
               skid_sel_d  = in_sel;
               state_d     = StFull;
            end else if (xfer) begin
               state_d = StEmpty;
            end
         end
         StFull: begin
            // in_ready is low here, so no request can arrive alongside the transfer.
            if (xfer) begin
               main_data_d = skid_data_q;
               main_sel_d  = skid_sel_q;
               state_d     = StOne;
            end
         end
         default: state_d = StEmpty;
      endcase
   end

   // Drop accounting: a drop in the same cycle as err_clr wins over the clear.
   always_comb begin
      err_d  = err_q;
      drop_d = drop_q;
      if (drop) begin
         err_d  = 1'b1;
         drop_d = err_clr ? 8'd1 : ((drop_q == 8'hFF) ? 8'hFF : drop_q + 8'd1);
      end else if (err_clr) begin
         err_d  = 1'b0;
         drop_d = 8'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q     <= StEmpty;
         main_data_q <= '0;
         main_sel_q  <= '0;
         skid_data_q <= '0;
         skid_sel_q  <= '0;
         err_q       <= 1'b0;
         drop_q      <= 8'd0;
      end else begin
         state_q     <= state_d;
         main_data_q <= main_data_d;
         main_sel_q  <= main_sel_d;
         skid_data_q <= skid_data_d;
         skid_sel_q  <= skid_sel_d;
         err_q       <= err_d;
         drop_q      <= drop_d;
      end
   end

   assign in_ready   = (state_q != StFull);
   assign out_valid  = (state_q != StEmpty);
   assign out_data   = main_data_q;
   assign out_sel    = main_sel_q;
   assign err_sel    = err_q;
   assign drop_count = drop_q;

endmodule

// File: tb/tb_bus_mux_pipe.sv
// Self-checking bench for bus_mux_pipe: directed scenarios plus a randomized run, all checked
// against a queue-based reference model (occupancy 0..2, FIFO order, drop counter).
module tb_bus_mux_pipe;

   localparam int unsigned WIDTH  = 32;
   localparam int unsigned NUM_IN = 3;
   localparam int unsigned SEL_W  = 2;

   logic                    clk = 1'b0;
   logic                    clr;
   logic [NUM_IN*WIDTH-1:0] in_data;
   logic [SEL_W-1:0]        in_sel;
   logic                    in_valid;
   logic                    in_ready;
   logic [WIDTH-1:0]        out_data;
   logic [SEL_W-1:0]        out_sel;
   logic                    out_valid;
   logic                    out_ready;
   logic                    err_sel;
   logic                    err_clr;
   logic [7:0]              drop_count;

   int total = 0;
   int bad   = 0;

   // Reference model state.
   logic [SEL_W+WIDTH-1:0] mq[$];
   logic                   m_err;
   int                     m_cnt;

   logic [WIDTH-1:0] vals[3];

   always #5 clk = ~clk;

   bus_mux_pipe #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) dut (
      .clk        (clk),
      .clr        (clr),
      .in_data    (in_data),
      .in_sel     (in_sel),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_data   (out_data),
      .out_sel    (out_sel),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .err_sel    (err_sel),
      .err_clr    (err_clr),
      .drop_count (drop_count)
   );

   // Advance the model by one edge using the current inputs, then clock the DUT.
   task automatic step();
      bit acc, xfer;
      logic [WIDTH-1:0] d;
      acc  = in_valid && (mq.size() < 2);
      xfer = (mq.size() > 0) && out_ready;
      if (clr) begin
         mq.delete();
         m_err = 1'b0;
         m_cnt = 0;
      end else begin
         if (xfer) void'(mq.pop_front());
         if (acc && int'(in_sel) < NUM_IN) begin
            d = in_data[int'(in_sel)*WIDTH +: WIDTH];
            mq.push_back({in_sel, d});
         end
         if (acc && int'(in_sel) >= NUM_IN) begin
            m_err = 1'b1;
            m_cnt = err_clr ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
         end else if (err_clr) begin
            m_err = 1'b0;
            m_cnt = 0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      clr = 1'b1; in_valid = 1'b0; in_sel = '0; out_ready = 1'b0; err_clr = 1'b0;
      in_data = {vals[2], vals[1], vals[0]};
      step();
      step();
      clr = 1'b0;
      total += 6;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
      if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
      if (out_data !== '0) begin bad++; $display("FAIL reset_out_data got=%h want=0", out_data); end
      if (out_sel !== '0) begin bad++; $display("FAIL reset_out_sel got=%0d want=0", out_sel); end
      if (err_sel !== 1'b0) begin bad++; $display("FAIL reset_err_sel got=%b want=0", err_sel); end
      if (drop_count !== 8'd0) begin
         bad++; $display("FAIL reset_drop_count got=%0d want=0", drop_count);
      end
   endtask

   task automatic test_stream();
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_sel = SEL_W'(i);
         step();
         total += 4;
         if (out_valid !== 1'b1) begin bad++; $display("FAIL stream_valid[%0d] got=%b want=1", i, out_valid); end
         if (out_data !== vals[i]) begin
            bad++; $display("FAIL stream_data[%0d] got=%h want=%h", i, out_data, vals[i]);
         end
         if (out_sel !== SEL_W'(i)) begin
            bad++; $display("FAIL stream_sel[%0d] got=%0d want=%0d", i, out_sel, i);
         end
         if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_ready[%0d] got=%b want=1", i, in_ready); end
      end
      in_valid = 1'b0;
      step();
   endtask

   task automatic test_back_pressure();
      out_ready = 1'b0;
      in_valid = 1'b1; in_sel = 2'd1;
      step();
      in_sel = 2'd2;
      step();
      in_valid = 1'b0;
      total += 2;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full_ready got=%b want=0", in_ready); end
      if (out_data !== vals[1]) begin bad++; $display("FAIL bp_full_data got=%h want=%h", out_data, vals[1]); end
      step();
      total += 2;
      if (out_data !== vals[1]) begin bad++; $display("FAIL bp_hold_data got=%h want=%h", out_data, vals[1]); end
      if (out_sel !== 2'd1) begin bad++; $display("FAIL bp_hold_sel got=%0d want=1", out_sel); end
      out_ready = 1'b1;
      step();
      total += 3;
      if (out_data !== vals[2]) begin bad++; $display("FAIL bp_second_data got=%h want=%h", out_data, vals[2]); end
      if (out_sel !== 2'd2) begin bad++; $display("FAIL bp_second_sel got=%0d want=2", out_sel); end
      if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_return got=%b want=1", in_ready); end
      step();
      total += 1;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drained got=%b want=0", out_valid); end
   endtask

   task automatic test_out_of_range();
      out_ready = 1'b1;
      in_valid = 1'b1; in_sel = 2'd0;
      step();
      total += 1;
      if (out_data !== vals[0]) begin bad++; $display("FAIL oor_first got=%h want=%h", out_data, vals[0]); end
      in_sel = 2'd3;
      step();
      total += 2;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL oor_no_store got=%b want=0", out_valid); end
      if (in_ready !== 1'b1) begin bad++; $display("FAIL oor_ready got=%b want=1", in_ready); end
      in_sel = 2'd1;
      step();
      in_valid = 1'b0;
      total += 4;
      if (out_valid !== 1'b1) begin bad++; $display("FAIL oor_next_valid got=%b want=1", out_valid); end
      if (out_data !== vals[1]) begin bad++; $display("FAIL oor_next got=%h want=%h", out_data, vals[1]); end
      if (err_sel !== 1'b1) begin bad++; $display("FAIL oor_err got=%b want=1", err_sel); end
      if (drop_count !== 8'd1) begin bad++; $display("FAIL oor_count got=%0d want=1", drop_count); end
      step();
   endtask

   task automatic test_saturation();
      out_ready = 1'b1;
      in_valid = 1'b1; in_sel = 2'd3;
      repeat (300) step();
      in_valid = 1'b0;
      total += 2;
      if (drop_count !== 8'd255) begin bad++; $display("FAIL sat_count got=%0d want=255", drop_count); end
      if (err_sel !== 1'b1) begin bad++; $display("FAIL sat_err got=%b want=1", err_sel); end
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      total += 2;
      if (drop_count !== 8'd0) begin bad++; $display("FAIL clr_count got=%0d want=0", drop_count); end
      if (err_sel !== 1'b0) begin bad++; $display("FAIL clr_err got=%b want=0", err_sel); end
      err_clr = 1'b1; in_valid = 1'b1; in_sel = 2'd3;
      step();
      err_clr = 1'b0; in_valid = 1'b0;
      total += 2;
      if (drop_count !== 8'd1) begin bad++; $display("FAIL clrset_count got=%0d want=1", drop_count); end
      if (err_sel !== 1'b1) begin bad++; $display("FAIL clrset_err got=%b want=1", err_sel); end
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      in_valid = 1'b1; in_sel = 2'd0;
      step();
      in_sel = 2'd2;
      step();
      total += 1;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL mid_full got=%b want=0", in_ready); end
      clr = 1'b1; in_sel = 2'd1; out_ready = 1'b1;
      step();
      clr = 1'b0; in_valid = 1'b0;
      total += 4;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b want=0", out_valid); end
      if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_ready got=%b want=1", in_ready); end
      if (out_data !== '0) begin bad++; $display("FAIL mid_data got=%h want=0", out_data); end
      if (out_sel !== '0) begin bad++; $display("FAIL mid_sel got=%0d want=0", out_sel); end
      for (int i = 0; i < 3; i++) begin
         step();
         total += 1;
         if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_stale[%0d] got=%b want=0", i, out_valid); end
      end
   endtask

   task automatic test_random();
      logic [SEL_W+WIDTH-1:0] head;
      for (int c = 0; c < 600; c++) begin
         in_data   = {$urandom, $urandom, $urandom};
         in_valid  = ($urandom_range(0, 3) != 0);
         in_sel    = SEL_W'($urandom_range(0, 3));
         out_ready = ($urandom_range(0, 2) != 0);
         err_clr   = ($urandom_range(0, 31) == 0);
         step();
         total += 4;
         if (in_ready !== (mq.size() < 2)) begin
            bad++; $display("FAIL rnd_ready[%0d] got=%b want=%b", c, in_ready, mq.size() < 2);
         end
         if (out_valid !== (mq.size() > 0)) begin
            bad++; $display("FAIL rnd_valid[%0d] got=%b want=%b", c, out_valid, mq.size() > 0);
         end
         if (err_sel !== m_err) begin bad++; $display("FAIL rnd_err[%0d] got=%b want=%b", c, err_sel, m_err); end
         if (drop_count !== 8'(m_cnt)) begin
            bad++; $display("FAIL rnd_count[%0d] got=%0d want=%0d", c, drop_count, m_cnt);
         end
         if (mq.size() > 0) begin
            head = mq[0];
            total += 1;
            if ({out_sel, out_data} !== head) begin
               bad++; $display("FAIL rnd_out[%0d] got=%h want=%h", c, {out_sel, out_data}, head);
            end
         end
      end
      in_valid = 1'b0; err_clr = 1'b0;
   endtask

   initial begin
      vals[0] = 32'hAAAA0000;
      vals[1] = 32'hBBBB1111;
      vals[2] = 32'hCCCC2222;
      m_err = 1'b0;
      m_cnt = 0;
      test_reset();
      test_stream();
      test_back_pressure();
      test_out_of_range();
      test_saturation();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
